// File: rtl/exec_if.sv
// Execute-stage bus: the instruction fields coming from the register-read
// stage and the register-file write port, stall and flags going back.
//   master : front end / register-read side (drives fields, observes results)
//   slave  : exec_stage
// Signals:
//   valid_in, operand_a, operand_b, adderAO, adderBO, dmaddrO, destO, opcodeO
//   write, wR, dataIn, stall, zero, carry
interface exec_if #(
    parameter int unsigned DATA_W = 8
);
    logic              valid_in;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [2:0]        adderAO;
    logic [2:0]        adderBO;
    logic [3:0]        dmaddrO;
    logic [2:0]        destO;
    logic [3:0]        opcodeO;
    logic              write;
    logic [2:0]        wR;
    logic [DATA_W-1:0] dataIn;
    logic              stall;
    logic              zero;
    logic              carry;

    modport master (
        output valid_in, operand_a, operand_b, adderAO, adderBO,
               dmaddrO, destO, opcodeO,
        input  write, wR, dataIn, stall, zero, carry
    );

    modport slave (
        input  valid_in, operand_a, operand_b, adderAO, adderBO,
               dmaddrO, destO, opcodeO,
        output write, wR, dataIn, stall, zero, carry
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage of the 8-bit pipelined processor.
// Performs ALU ops, data-memory load/store and a shift-add multiply
// (one multiplier bit per cycle, front end stalled meanwhile), and drives the
// register-file write port one cycle after an instruction is accepted.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : exec_if.slave (instruction fields in; write/wR/dataIn, stall,
//            zero, carry out -- all outputs registered)
// Optional feature:
//   EXEC_FWD_EN : when defined, the previous cycle's register write is
//                 forwarded onto operand A/B when its index matches.
module exec_stage #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DMEM_DEPTH = 16
) (
    input  logic  clk,
    input  logic  reset,
    exec_if.slave bus
);
    localparam int unsigned AW = $clog2(DMEM_DEPTH);
    localparam int unsigned CW = $clog2(DATA_W);
    localparam int unsigned RW = 3;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [RW-1:0]     wr_q, wr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              stall_q, stall_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;

    logic [DATA_W-1:0] mul_a_q, mul_a_d;
    logic [DATA_W-1:0] mul_b_q, mul_b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_sum;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     mul_dest_q, mul_dest_d;

    logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

    logic              accept;
    logic [DATA_W-1:0] a_eff;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_wr;
    logic              alu_sets_carry;
    logic              alu_carry;
    logic              dmem_we;

    // Fields are only taken in IDLE; stalled and DONE cycles ignore valid_in.
    assign accept = bus.valid_in && (state_q == ST_IDLE);

    // Operand selection: bypass the write currently on the register port.
`ifdef EXEC_FWD_EN
    assign a_eff = (write_q && (wr_q == bus.adderAO)) ? data_q : bus.operand_a;
    assign b_eff = (write_q && (wr_q == bus.adderBO)) ? data_q : bus.operand_b;
`else
    assign a_eff = bus.operand_a;
    assign b_eff = bus.operand_b;
    logic unused_fwd_idx;
    assign unused_fwd_idx = ^{bus.adderAO, bus.adderBO};
`endif

    // Single-cycle datapath; the multiply is sequenced by the FSM below.
    always_comb begin
        sum_ext        = '0;
        alu_res        = '0;
        alu_wr         = 1'b0;
        alu_sets_carry = 1'b0;
        alu_carry      = 1'b0;
        dmem_we        = 1'b0;
        case (bus.opcodeO)
            OP_ADD: begin
                sum_ext        = {1'b0, a_eff} + {1'b0, b_eff};
                alu_res        = sum_ext[DATA_W-1:0];
                alu_carry      = sum_ext[DATA_W];
                alu_sets_carry = 1'b1;
                alu_wr         = 1'b1;
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                sum_ext        = {1'b0, a_eff} - {1'b0, b_eff};
                alu_res        = sum_ext[DATA_W-1:0];
                alu_carry      = sum_ext[DATA_W];
                alu_sets_carry = 1'b1;
                alu_wr         = 1'b1;
            end
            OP_AND: begin
                alu_res = a_eff & b_eff;
                alu_wr  = 1'b1;
            end
            OP_OR: begin
                alu_res = a_eff | b_eff;
                alu_wr  = 1'b1;
            end
            OP_XOR: begin
                alu_res = a_eff ^ b_eff;
                alu_wr  = 1'b1;
            end
            OP_SHL: begin
                alu_res = a_eff << b_eff[CW-1:0];
                alu_wr  = 1'b1;
            end
            OP_SHR: begin
                alu_res = a_eff >> b_eff[CW-1:0];
                alu_wr  = 1'b1;
            end
            OP_LD: begin
                alu_res = dmem_q[bus.dmaddrO[AW-1:0]];
                alu_wr  = 1'b1;
            end
            OP_ST: begin
                dmem_we = accept;
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        write_d    = 1'b0;
        wr_d       = wr_q;
        data_d     = data_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mul_dest_d = mul_dest_q;
        acc_sum    = acc_q + (mul_b_q[0] ? mul_a_q : '0);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.opcodeO == OP_MUL) begin
                        state_d    = ST_MUL;
                        mul_a_d    = a_eff;
                        mul_b_d    = b_eff;
                        acc_d      = '0;
                        cnt_d      = '0;
                        mul_dest_d = bus.destO;
                    end else if (alu_wr) begin
                        write_d = 1'b1;
                        wr_d    = bus.destO;
                        data_d  = alu_res;
                        zero_d  = (alu_res == '0);
                        if (alu_sets_carry) begin
                            carry_d = alu_carry;
                        end
                    end
                end
            end
            ST_MUL: begin
                // Multiplicand walks left, multiplier walks right; only the
                // low DATA_W bits of the product are kept.
                acc_d   = acc_sum;
                mul_a_d = mul_a_q << 1;
                mul_b_d = mul_b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_W - 1)) begin
                    state_d = ST_DONE;
                    write_d = 1'b1;
                    wr_d    = mul_dest_q;
                    data_d  = acc_sum;
                    zero_d  = (acc_sum == '0);
                end
            end
            ST_DONE: begin
                // Product is on the write port this cycle; the still-presented
                // MUL fields must not be re-accepted.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        stall_d = (state_d == ST_MUL);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            wr_q       <= '0;
            data_q     <= '0;
            stall_q    <= 1'b0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mul_dest_q <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            stall_q    <= stall_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mul_dest_q <= mul_dest_d;
        end
    end

    // Data memory: written on the accepting edge so a following LD sees it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) begin
                dmem_q[i] <= '0;
            end
        end else if (dmem_we) begin
            dmem_q[bus.dmaddrO[AW-1:0]] <= a_eff;
        end
    end

    assign bus.write  = write_q;
    assign bus.wR     = wr_q;
    assign bus.dataIn = data_q;
    assign bus.stall  = stall_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;

endmodule

// File: tb/tb_exec_stage.sv
// Testbench for exec_stage: directed scenarios followed by random
// instruction streams, checked by a queue-based scoreboard fed from a
// behavioural model of the execute stage.
module tb_exec_stage;
    localparam int unsigned DATA_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    exec_if #(.DATA_W(DATA_W)) bus ();

    exec_stage #(.DATA_W(DATA_W), .DMEM_DEPTH(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected register write, tagged with the cycle it must be visible in.
    typedef struct {
        int         cyc;
        logic [2:0] wr;
        logic [7:0] data;
        logic       z;
        logic       c;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state.
    logic [7:0] m_mem [16];
    bit         m_zero   = 1'b0;
    bit         m_carry  = 1'b0;
    int         busy_end = 0;
    int         stall_lo = 1;
    int         stall_hi = 0;
    int         lw_cyc   = -1;
    logic [2:0] lw_reg   = '0;
    logic [7:0] lw_data  = '0;
    bit         mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: drive fields, then let the model predict the
    // effect of the upcoming rising edge.
    task automatic step(input bit rst, input bit v, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] ia, input logic [2:0] ib,
                        input logic [2:0] dest, input logic [3:0] addr);
        int         e;
        int         wc;
        int         sum;
        bit         wr;
        logic [7:0] ae;
        logic [7:0] be;
        logic [7:0] r;
        @(negedge clk);
        #2;
        reset         = rst;
        bus.valid_in  = v;
        bus.opcodeO   = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.adderAO   = ia;
        bus.adderBO   = ib;
        bus.destO     = dest;
        bus.dmaddrO   = addr;
        e = cyc + 1;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_zero   = 1'b0;
            m_carry  = 1'b0;
            busy_end = 0;
            if (stall_hi >= e) stall_hi = e - 1;
            while (exp_q.size() > 0 && exp_q[$].cyc >= e) void'(exp_q.pop_back());
            lw_cyc = -1;
        end else if (v && e > busy_end) begin
            ae = a;
            be = b;
`ifdef EXEC_FWD_EN
            if (lw_cyc == cyc && lw_reg == ia) ae = lw_data;
            if (lw_cyc == cyc && lw_reg == ib) be = lw_data;
`endif
            wr = 1'b1;
            wc = e;
            r  = 8'h00;
            case (op)
                4'h1: begin
                    sum     = int'(ae) + int'(be);
                    r       = 8'(sum % 256);
                    m_carry = (sum > 255);
                end
                4'h2: begin
                    r       = 8'((int'(ae) - int'(be) + 256) % 256);
                    m_carry = (ae < be);
                end
                4'h3: r = ae & be;
                4'h4: r = ae | be;
                4'h5: r = ae ^ be;
                4'h6: r = 8'((int'(ae) * (1 << int'(be[2:0]))) % 256);
                4'h7: r = 8'(int'(ae) / (1 << int'(be[2:0])));
                4'h8: r = m_mem[addr];
                4'h9: begin
                    m_mem[addr] = ae;
                    wr = 1'b0;
                end
                4'hA: begin
                    r        = 8'((int'(ae) * int'(be)) % 256);
                    wc       = e + DATA_W;
                    busy_end = e + DATA_W + 1;
                    stall_lo = e;
                    stall_hi = e + DATA_W - 1;
                end
                default: wr = 1'b0;
            endcase
            if (wr) begin
                m_zero = (r == 8'h00);
                exp_q.push_back('{wc, dest, r, m_zero, m_carry});
                lw_cyc  = wc;
                lw_reg  = dest;
                lw_data = r;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0, 4'h0);
    endtask

    // Monitor: every cycle compare stall and any register write with the
    // scoreboard.
    initial begin
        exp_t ent;
        bit   exp_stall;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_stall = (cyc >= stall_lo && cyc <= stall_hi);
                chk("stall", 32'(bus.stall), 32'(exp_stall));
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    ent = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_write: got write=0 expected wR=%0d dataIn=%0h (cycle %0d)",
                             ent.wr, ent.data, ent.cyc);
                end
                if (bus.write === 1'b1) begin
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got write=1 wR=%0d dataIn=%0h expected write=0 (cycle %0d)",
                                 bus.wR, bus.dataIn, cyc);
                    end else begin
                        ent = exp_q.pop_front();
                        chk("wR", 32'(bus.wR), 32'(ent.wr));
                        chk("dataIn", 32'(bus.dataIn), 32'(ent.data));
                        chk("zero", 32'(bus.zero), 32'(ent.z));
                        chk("carry", 32'(bus.carry), 32'(ent.c));
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    ent = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_write: got write=0 expected wR=%0d dataIn=%0h (cycle %0d)",
                             ent.wr, ent.data, cyc);
                end
            end
        end
    end

    initial begin
        bus.valid_in  = 1'b0;
        bus.opcodeO   = 4'h0;
        bus.operand_a = 8'h00;
        bus.operand_b = 8'h00;
        bus.adderAO   = 3'd0;
        bus.adderBO   = 3'd0;
        bus.destO     = 3'd0;
        bus.dmaddrO   = 4'h0;

        // Reset state
        step(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0, 4'h0);
        step(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0, 4'h0);
        idle();
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_wR", 32'(bus.wR), 32'd0);
        chk("rst_dataIn", 32'(bus.dataIn), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        chk("rst_carry", 32'(bus.carry), 32'd0);
        mon_en = 1'b1;

        // ADD with carry out
        step(1'b0, 1'b1, 4'h1, 8'h22, 8'hFF, 3'd0, 3'd0, 3'd3, 4'h0);
        idle();
        chk("t1_write", 32'(bus.write), 32'd1);
        chk("t1_wR", 32'(bus.wR), 32'd3);
        chk("t1_dataIn", 32'(bus.dataIn), 32'h21);
        chk("t1_carry", 32'(bus.carry), 32'd1);
        chk("t1_zero", 32'(bus.zero), 32'd0);

        // SUB to zero
        step(1'b0, 1'b1, 4'h2, 8'h44, 8'h44, 3'd0, 3'd0, 3'd4, 4'h0);
        idle();
        chk("t2_dataIn", 32'(bus.dataIn), 32'h00);
        chk("t2_zero", 32'(bus.zero), 32'd1);
        chk("t2_carry", 32'(bus.carry), 32'd0);

        // ST then back-to-back LD
        step(1'b0, 1'b1, 4'h9, 8'h5A, 8'h00, 3'd0, 3'd0, 3'd6, 4'h3);
        step(1'b0, 1'b1, 4'h8, 8'h00, 8'h00, 3'd0, 3'd0, 3'd5, 4'h3);
        chk("t3_st_write", 32'(bus.write), 32'd0);
        idle();
        chk("t3_ld_wR", 32'(bus.wR), 32'd5);
        chk("t3_ld_dataIn", 32'(bus.dataIn), 32'h5A);

        // MUL: 8 stalled cycles with junk presented, product on cycle 9
        step(1'b0, 1'b1, 4'hA, 8'h11, 8'h0F, 3'd0, 3'd0, 3'd2, 4'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 4'h1, 8'($urandom), 8'($urandom), 3'd0, 3'd0, 3'd7, 4'h0);
            chk("t4_stall", 32'(bus.stall), 32'd1);
            chk("t4_nowrite", 32'(bus.write), 32'd0);
        end
        step(1'b0, 1'b1, 4'h1, 8'h01, 8'h01, 3'd0, 3'd0, 3'd7, 4'h0);
        chk("t4_write", 32'(bus.write), 32'd1);
        chk("t4_wR", 32'(bus.wR), 32'd2);
        chk("t4_dataIn", 32'(bus.dataIn), 32'hFF);
        chk("t4_stall_done", 32'(bus.stall), 32'd0);
        idle();
        chk("t4_done_ignored", 32'(bus.write), 32'd0);

        // Reset during MUL cycle 4
        step(1'b0, 1'b1, 4'hA, 8'h03, 8'h05, 3'd0, 3'd0, 3'd1, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 4'h3, 8'h00, 8'h00, 3'd0, 3'd0, 3'd7, 4'h0);
        end
        step(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0, 4'h0);
        idle();
        chk("t5_stall", 32'(bus.stall), 32'd0);
        chk("t5_write", 32'(bus.write), 32'd0);
        chk("t5_wR", 32'(bus.wR), 32'd0);
        chk("t5_dataIn", 32'(bus.dataIn), 32'd0);
        chk("t5_zero", 32'(bus.zero), 32'd0);
        chk("t5_carry", 32'(bus.carry), 32'd0);
        for (int i = 0; i < 10; i++) idle();
        step(1'b0, 1'b1, 4'h1, 8'h01, 8'h02, 3'd0, 3'd0, 3'd6, 4'h0);
        idle();
        chk("t5_add_wR", 32'(bus.wR), 32'd6);
        chk("t5_add_dataIn", 32'(bus.dataIn), 32'h03);
        step(1'b0, 1'b1, 4'h8, 8'h00, 8'h00, 3'd0, 3'd0, 3'd5, 4'h3);
        idle();
        chk("t5_dmem_cleared", 32'(bus.dataIn), 32'h00);

        // Dependent ADDs
        step(1'b0, 1'b1, 4'h1, 8'h22, 8'h44, 3'd1, 3'd2, 3'd1, 4'h0);
        step(1'b0, 1'b1, 4'h1, 8'h22, 8'h22, 3'd1, 3'd1, 3'd3, 4'h0);
        idle();
`ifdef EXEC_FWD_EN
        chk("t6_fwd_dataIn", 32'(bus.dataIn), 32'hCC);
`else
        chk("t6_nofwd_dataIn", 32'(bus.dataIn), 32'h44);
`endif

        // Random instruction stream
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 8,
                 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 12; i++) idle();
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
